// File: rtl/riscv_multicycle.sv
// riscv_multicycle: multicycle RV32I-subset core with a single unified memory
// port (req/ready handshake), a controller FSM and one shared ALU.
// Illegal instructions and misaligned accesses or targets park the core in HALT.
module riscv_multicycle #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter bit          RV32E    = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc,
    output logic        retire,
    output logic        halted
);

    localparam int unsigned RIDX = RV32E ? 4 : 5;
    localparam int unsigned NREG = 1 << RIDX;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] imm_q, imm_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] mdr_q, mdr_d;
    logic [31:0] rf_q [NREG];

    logic        rf_we;
    logic [31:0] rf_wdata;

    logic        req_c, we_c, retire_c;
    logic [31:0] addr_c, wdata_c;

    // Instruction fields
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign f3     = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign f7     = ir_q[31:25];

    logic is_lw, is_sw, is_r, is_i, is_br, is_jal;
    logic uses_rs1, uses_rs2, uses_rd, reg_ok, legal;
    logic alu_f3_ok;

    // Classify the latched instruction and check register indices in RV32E mode
    always_comb begin
        alu_f3_ok = (f3 == 3'b000) || (f3 == 3'b111) || (f3 == 3'b110) || (f3 == 3'b010);
        is_lw     = (opcode == OP_LOAD)  && (f3 == 3'b010);
        is_sw     = (opcode == OP_STORE) && (f3 == 3'b010);
        is_r      = (opcode == OP_REG) &&
                    (((f7 == 7'b0000000) && alu_f3_ok) ||
                     ((f7 == 7'b0100000) && (f3 == 3'b000)));
        is_i      = (opcode == OP_IMM) && alu_f3_ok;
        is_br     = (opcode == OP_BRANCH) && ((f3 == 3'b000) || (f3 == 3'b001));
        is_jal    = (opcode == OP_JAL);
        uses_rs1  = is_lw || is_sw || is_r || is_i || is_br;
        uses_rs2  = is_sw || is_r || is_br;
        uses_rd   = is_lw || is_r || is_i || is_jal;
        reg_ok    = !RV32E ||
                    !((uses_rs1 && rs1[4]) || (uses_rs2 && rs2[4]) || (uses_rd && rd[4]));
        legal     = (is_lw || is_sw || is_r || is_i || is_br || is_jal) && reg_ok;
    end

    logic [31:0] imm_i, imm_s, imm_b, imm_j;

    assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

    logic [31:0] op2, alu_res, addr_sum, target, pc_plus4;
    logic        taken;

    // Shared ALU: register-register or register-immediate, plus address/target adders
    always_comb begin
        op2 = is_r ? b_q : imm_q;
        unique case (f3)
            3'b000:  alu_res = (is_r && f7[5]) ? (a_q - op2) : (a_q + op2);
            3'b111:  alu_res = a_q & op2;
            3'b110:  alu_res = a_q | op2;
            3'b010:  alu_res = {31'b0, ($signed(a_q) < $signed(op2))};
            default: alu_res = '0;
        endcase
        addr_sum = a_q + imm_q;
        target   = pc_q + imm_q;
        pc_plus4 = pc_q + 32'd4;
        taken    = f3[0] ? (a_q != b_q) : (a_q == b_q);
    end

    // Controller: next state, datapath latches, memory request and retire
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        imm_d    = imm_q;
        alu_d    = alu_q;
        mdr_d    = mdr_q;
        rf_we    = 1'b0;
        rf_wdata = '0;
        req_c    = 1'b0;
        we_c     = 1'b0;
        addr_c   = '0;
        wdata_c  = '0;
        retire_c = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                req_c  = 1'b1;
                addr_c = pc_q;
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d = (rs1 == 5'd0) ? '0 : rf_q[rs1[RIDX-1:0]];
                b_d = (rs2 == 5'd0) ? '0 : rf_q[rs2[RIDX-1:0]];
                if (is_jal)      imm_d = imm_j;
                else if (is_br)  imm_d = imm_b;
                else if (is_sw)  imm_d = imm_s;
                else             imm_d = imm_i;
                state_d = legal ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
                if (is_lw || is_sw) begin
                    alu_d   = addr_sum;
                    state_d = (addr_sum[1:0] != 2'b00) ? S_HALT : S_MEM;
                end else if (is_br) begin
                    if (taken && (target[1:0] != 2'b00)) begin
                        state_d = S_HALT;
                    end else begin
                        pc_d     = taken ? target : pc_plus4;
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end
                end else if (is_jal) begin
                    if (target[1:0] != 2'b00) begin
                        state_d = S_HALT;
                    end else begin
                        rf_we    = 1'b1;
                        rf_wdata = pc_plus4;
                        pc_d     = target;
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end
                end else begin
                    alu_d   = alu_res;
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                req_c   = 1'b1;
                we_c    = is_sw;
                addr_c  = alu_q;
                wdata_c = b_q;
                if (mem_ready) begin
                    if (is_sw) begin
                        pc_d     = pc_plus4;
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we    = 1'b1;
                rf_wdata = is_lw ? mdr_q : alu_q;
                pc_d     = pc_plus4;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
        end
    end

    // Register file write port; x0 is never written so it always reads zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_we && (rd != 5'd0)) begin
            rf_q[rd[RIDX-1:0]] <= rf_wdata;
        end
    end

    // Reset gates the bus combinationally so a pending access is dropped at once
    assign mem_req   = reset & req_c;
    assign mem_we    = reset & we_c;
    assign mem_addr  = reset ? addr_c  : '0;
    assign mem_wdata = reset ? wdata_c : '0;
    assign retire    = reset & retire_c;
    assign halted    = (state_q == S_HALT);
    assign pc        = pc_q;

endmodule

// File: tb/tb_riscv_multicycle.sv
// Directed testbench for riscv_multicycle: unified memory model with
// configurable wait states, retire/store logs and handshake/halt monitors.
module tb_riscv_multicycle;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req, mem_we, mem_ready, retire, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;

    riscv_multicycle #(
        .RESET_PC(32'h0000_0100),
        .RV32E   (1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .pc       (pc),
        .retire   (retire),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory images: words 0..63 data, words 64..127 code at 0x100
    logic [31:0] mem  [256];
    logic [31:0] prog [64];
    logic [31:0] dimg [64];
    int          wait_fetch = 0;
    int          wait_data  = 0;
    int          cnt;

    assign mem_ready = mem_req && (cnt >= (mem_we ? wait_data : wait_fetch));
    assign mem_rdata = mem[mem_addr[9:2]];

    // Memory model: reload while reset is low, count wait cycles, commit stores
    always @(posedge clk) begin
        if (!reset) begin
            cnt <= 0;
            for (int i = 0; i < 64; i++) begin
                mem[i]       <= dimg[i];
                mem[64 + i]  <= prog[i];
                mem[128 + i] <= '0;
                mem[192 + i] <= '0;
            end
        end else begin
            if (!mem_req || mem_ready) cnt <= 0;
            else                       cnt <= cnt + 1;
            if (mem_req && mem_ready && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
        end
    end

    // Logs of retires and completed transfers, cleared by reset
    int          cyc;
    int          ret_cyc [$];
    logic [31:0] ret_pc  [$];
    logic [31:0] st_addr [$];
    logic [31:0] st_data [$];
    int          data_xfers;
    int          total_stores = 0;

    always @(posedge clk) begin
        if (!reset) begin
            cyc = 0;
            ret_cyc.delete();
            ret_pc.delete();
            st_addr.delete();
            st_data.delete();
            data_xfers = 0;
        end else begin
            cyc++;
            if (retire) begin
                ret_cyc.push_back(cyc);
                ret_pc.push_back(pc);
            end
            if (mem_req && mem_ready) begin
                if (mem_addr < 32'h100) data_xfers++;
                if (mem_we) begin
                    st_addr.push_back(mem_addr);
                    st_data.push_back(mem_wdata);
                    total_stores++;
                end
            end
        end
    end

    // Handshake stability and halt stickiness monitor
    logic        p_req, p_we, p_ready, p_halt;
    logic [31:0] p_addr, p_wdata;
    int          unstable, halt_viol;

    always @(negedge clk) begin
        if (!reset) begin
            unstable  = 0;
            halt_viol = 0;
            p_req     = 1'b0;
            p_ready   = 1'b0;
            p_halt    = 1'b0;
        end else begin
            if (mem_req && p_req && !p_ready &&
                ({mem_we, mem_addr, mem_wdata} !== {p_we, p_addr, p_wdata})) unstable++;
            if (halted && (mem_req || retire)) halt_viol++;
            if (p_halt && !halted) halt_viol++;
            p_req   = mem_req;
            p_we    = mem_we;
            p_addr  = mem_addr;
            p_wdata = mem_wdata;
            p_ready = mem_ready;
            p_halt  = halted;
        end
    end

    // Instruction encoders
    function automatic logic [31:0] enc_i(input int op, input int f3, input int rd,
                                          input int rs1, input int imm);
        logic [31:0] v;
        v = imm;
        return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
    endfunction

    function automatic logic [31:0] enc_r(input int f7, input int f3, input int rd,
                                          input int rs1, input int rs2);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_s(input int rs2, input int rs1, input int imm);
        logic [31:0] v;
        v = imm;
        return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input int f3, input int rs1, input int rs2,
                                          input int imm);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input int rd, input int imm);
        logic [31:0] v;
        v = imm;
        return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'b1101111};
    endfunction

    function automatic logic [31:0] ADDI(input int rd, input int rs1, input int imm);
        return enc_i('h13, 0, rd, rs1, imm);
    endfunction
    function automatic logic [31:0] LW(input int rd, input int rs1, input int imm);
        return enc_i('h03, 2, rd, rs1, imm);
    endfunction
    function automatic logic [31:0] SW(input int rs2, input int rs1, input int imm);
        return enc_s(rs2, rs1, imm);
    endfunction
    function automatic logic [31:0] ADD(input int rd, input int rs1, input int rs2);
        return enc_r(0, 0, rd, rs1, rs2);
    endfunction
    function automatic logic [31:0] SLT(input int rd, input int rs1, input int rs2);
        return enc_r(0, 2, rd, rs1, rs2);
    endfunction
    function automatic logic [31:0] BEQ(input int rs1, input int rs2, input int imm);
        return enc_b(0, rs1, rs2, imm);
    endfunction
    function automatic logic [31:0] BNE(input int rs1, input int rs2, input int imm);
        return enc_b(1, rs1, rs2, imm);
    endfunction
    function automatic logic [31:0] JAL(input int rd, input int imm);
        return enc_j(rd, imm);
    endfunction

    task automatic clear_img();
        for (int i = 0; i < 64; i++) begin
            prog[i] = '0;
            dimg[i] = '0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_retires(input int n, input int maxc, input string tag);
        int i;
        i = 0;
        while ((ret_cyc.size() < n) && (i < maxc)) begin
            @(negedge clk);
            i++;
        end
        n_checks++;
        if (ret_cyc.size() < n) begin
            n_fail++;
            $display("FAIL %s_timeout: retires %0d, required %0d", tag, ret_cyc.size(), n);
        end
    endtask

    task automatic wait_halt(input int maxc, input string tag);
        int i;
        i = 0;
        while (!halted && (i < maxc)) begin
            @(negedge clk);
            i++;
        end
        n_checks++;
        if (halted !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_halt_timeout: halted %b, required 1", tag, halted);
        end
    endtask

    task automatic test_reset();
        clear_img();
        prog[0] = ADDI(1, 0, 7);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (pc !== 32'h100) begin
            n_fail++; $display("FAIL reset_pc: got %h, required 00000100", pc);
        end
        n_checks++;
        if ({mem_req, mem_we, retire, halted} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctrl: req/we/retire/halted %b, required 0000",
                               {mem_req, mem_we, retire, halted});
        end
        n_checks++;
        if ({mem_addr, mem_wdata} !== 64'h0) begin
            n_fail++; $display("FAIL reset_bus: addr %h wdata %h, required 0", mem_addr, mem_wdata);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h100}) begin
            n_fail++; $display("FAIL first_fetch: req %b we %b addr %h, required 1 0 00000100",
                               mem_req, mem_we, mem_addr);
        end
        wait_retires(1, 20, "reset");
        n_checks++;
        if (ret_cyc[0] !== 4) begin
            n_fail++; $display("FAIL first_retire_cycle: got %0d, required 4", ret_cyc[0]);
        end
        n_checks++;
        if (ret_pc[0] !== 32'h100) begin
            n_fail++; $display("FAIL first_retire_pc: got %h, required 00000100", ret_pc[0]);
        end
    endtask

    task automatic test_alu_wait();
        clear_img();
        prog[0] = ADDI(1, 0, 5);
        prog[1] = ADDI(2, 0, -3);
        prog[2] = ADD(3, 1, 2);
        prog[3] = SLT(4, 2, 1);
        prog[4] = SW(3, 0, 'h40);
        prog[5] = SW(4, 0, 'h44);
        wait_fetch = 2;
        wait_data  = 0;
        do_reset();
        wait_halt(100, "alu");
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (ret_cyc[k] !== 6 * (k + 1)) begin
                n_fail++; $display("FAIL alu_retire_cycle_%0d: got %0d, required %0d",
                                   k, ret_cyc[k], 6 * (k + 1));
            end
        end
        n_checks++;
        if (ret_cyc.size() !== 6) begin
            n_fail++; $display("FAIL alu_retire_count: got %0d, required 6", ret_cyc.size());
        end
        n_checks++;
        if (mem[16] !== 32'd2) begin
            n_fail++; $display("FAIL alu_add_x3: got %h, required 00000002", mem[16]);
        end
        n_checks++;
        if (mem[17] !== 32'd1) begin
            n_fail++; $display("FAIL alu_slt_x4: got %h, required 00000001", mem[17]);
        end
        n_checks++;
        if (unstable !== 0) begin
            n_fail++; $display("FAIL alu_req_stable: %0d changes while waiting, required 0", unstable);
        end
        wait_fetch = 0;
    endtask

    task automatic test_load_store();
        clear_img();
        prog[0] = ADDI(3, 0, 2);
        prog[1] = SW(3, 0, 8);
        prog[2] = LW(5, 0, 8);
        prog[3] = SW(5, 0, 'h48);
        do_reset();
        wait_retires(4, 60, "ls");
        n_checks++;
        if ({st_addr[0], st_data[0]} !== {32'd8, 32'd2}) begin
            n_fail++; $display("FAIL ls_store: addr %h data %h, required 00000008 00000002",
                               st_addr[0], st_data[0]);
        end
        n_checks++;
        if (ret_cyc[2] - ret_cyc[1] !== 5) begin
            n_fail++; $display("FAIL ls_lw_latency: got %0d, required 5", ret_cyc[2] - ret_cyc[1]);
        end
        n_checks++;
        if (ret_cyc[1] - ret_cyc[0] !== 4) begin
            n_fail++; $display("FAIL ls_sw_latency: got %0d, required 4", ret_cyc[1] - ret_cyc[0]);
        end
        n_checks++;
        if ({st_addr[1], st_data[1]} !== {32'h48, 32'd2}) begin
            n_fail++; $display("FAIL ls_load_value: addr %h data %h, required 00000048 00000002",
                               st_addr[1], st_data[1]);
        end
    endtask

    task automatic test_control();
        logic [31:0] exp_pc [12];
        exp_pc = '{32'h100, 32'h104, 32'h108, 32'h110, 32'h120, 32'h128,
                   32'h12C, 32'h130, 32'h134, 32'h138, 32'h134, 32'h138};
        clear_img();
        dimg[21] = 32'hDEAD_BEEF;
        dimg[22] = 32'hDEAD_BEEF;
        prog[0]  = ADDI(1, 0, 1);
        prog[1]  = ADDI(2, 0, 2);
        prog[2]  = BNE(1, 2, 8);
        prog[3]  = ADDI(6, 0, 99);
        prog[4]  = JAL(1, 16);
        prog[5]  = ADDI(6, 0, 77);
        prog[6]  = ADDI(6, 0, 77);
        prog[7]  = ADDI(6, 0, 77);
        prog[8]  = JAL(0, 8);
        prog[9]  = ADDI(6, 0, 55);
        prog[10] = BEQ(1, 2, 8);
        prog[11] = SW(1, 0, 'h50);
        prog[12] = SW(6, 0, 'h54);
        prog[13] = SW(0, 0, 'h58);
        prog[14] = BEQ(1, 1, -4);
        do_reset();
        wait_retires(12, 100, "ctrl");
        for (int k = 0; k < 12; k++) begin
            n_checks++;
            if (ret_pc[k] !== exp_pc[k]) begin
                n_fail++; $display("FAIL ctrl_pc_%0d: got %h, required %h", k, ret_pc[k], exp_pc[k]);
            end
        end
        n_checks++;
        if (ret_cyc[2] - ret_cyc[1] !== 3) begin
            n_fail++; $display("FAIL ctrl_branch_latency: got %0d, required 3", ret_cyc[2] - ret_cyc[1]);
        end
        n_checks++;
        if (ret_cyc[3] - ret_cyc[2] !== 3) begin
            n_fail++; $display("FAIL ctrl_jal_latency: got %0d, required 3", ret_cyc[3] - ret_cyc[2]);
        end
        n_checks++;
        if (mem[20] !== 32'h114) begin
            n_fail++; $display("FAIL ctrl_jal_link: got %h, required 00000114", mem[20]);
        end
        n_checks++;
        if (mem[21] !== 32'h0) begin
            n_fail++; $display("FAIL ctrl_skipped_x6: got %h, required 00000000", mem[21]);
        end
        n_checks++;
        if (mem[22] !== 32'h0) begin
            n_fail++; $display("FAIL ctrl_x0_zero: got %h, required 00000000", mem[22]);
        end
    endtask

    task automatic fault_case(input string tag, input logic [31:0] i0, input logic [31:0] i1,
                              input int exp_ret, input logic [31:0] exp_pc);
        clear_img();
        prog[0] = i0;
        prog[1] = i1;
        do_reset();
        wait_halt(30, tag);
        repeat (6) @(negedge clk);
        n_checks++;
        if ({halted, mem_req, retire} !== 3'b100) begin
            n_fail++; $display("FAIL %s_state: halted/req/retire %b, required 100",
                               tag, {halted, mem_req, retire});
        end
        n_checks++;
        if (ret_cyc.size() !== exp_ret) begin
            n_fail++; $display("FAIL %s_retires: got %0d, required %0d", tag, ret_cyc.size(), exp_ret);
        end
        n_checks++;
        if (pc !== exp_pc) begin
            n_fail++; $display("FAIL %s_pc: got %h, required %h", tag, pc, exp_pc);
        end
        n_checks++;
        if ({halt_viol, data_xfers} !== {32'd0, 32'd0}) begin
            n_fail++; $display("FAIL %s_sticky: halt violations %0d data accesses %0d, required 0 0",
                               tag, halt_viol, data_xfers);
        end
    endtask

    task automatic test_fault();
        fault_case("fault_lw_misaligned", ADDI(1, 0, 9), LW(1, 0, 2), 1, 32'h104);
        fault_case("fault_opcode", 32'h0000_007F, 32'h0, 0, 32'h100);
        fault_case("fault_rv32e", ADDI(1, 0, 3), ADD(20, 1, 1), 1, 32'h104);
        fault_case("fault_branch_target", ADDI(1, 0, 1), BNE(1, 0, 6), 1, 32'h104);
    endtask

    task automatic test_reset_mid();
        int i;
        int snap;
        clear_img();
        prog[0]   = ADDI(3, 0, 2);
        prog[1]   = SW(3, 0, 8);
        wait_data = 50;
        do_reset();
        i = 0;
        while (!(mem_req && mem_we) && (i < 40)) begin
            @(negedge clk);
            i++;
        end
        n_checks++;
        if ((mem_req && mem_we) !== 1'b1) begin
            n_fail++; $display("FAIL mid_store_wait: req %b we %b, required 1 1", mem_req, mem_we);
        end
        snap = total_stores;
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({mem_req, mem_we} !== 2'b00) begin
            n_fail++; $display("FAIL mid_async_drop: req %b we %b, required 0 0", mem_req, mem_we);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (total_stores !== snap) begin
            n_fail++; $display("FAIL mid_no_store: stores %0d, required %0d", total_stores, snap);
        end
        wait_data = 0;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h100}) begin
            n_fail++; $display("FAIL mid_refetch: req %b we %b addr %h, required 1 0 00000100",
                               mem_req, mem_we, mem_addr);
        end
        wait_retires(2, 30, "mid");
        n_checks++;
        if (ret_pc[1] !== 32'h104) begin
            n_fail++; $display("FAIL mid_resume_pc: got %h, required 00000104", ret_pc[1]);
        end
    endtask

    initial begin
        reset = 1'b0;
        test_reset();
        test_alu_wait();
        test_load_store();
        test_control();
        test_fault();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
